instruction_fetch: RTL and testbench
====================================

// Module: instruction_fetch
// PURPOSE
//  Fetch stage feeding the single-cycle execute datapath. Owns the fetch PC and
//  issues word reads to a synchronous program memory (1-cycle read latency).
//  Buffers returned words with their PC in a small FIFO and presents them over
//  a valid/ready handshake. Accepts PC redirects (jal/branch targets) from downstream.
// PARAMETERS
//  PROGRAM_MEMORY_SIZE_WORDS  64  words in program memory; power of 2
//  RESET_PC                   0   fetch PC after reset; word aligned
//  FIFO_DEPTH                 2   fetch buffer entries; power of 2, >=2
// PORTS
//  clk             in   1   clock; all state on rising edge
//  reset           in   1   synchronous, active-high
//  mem_req         out  1   read request this cycle
//  mem_addr        out  AW  word index = fetch_pc[AW+1:2], AW=$clog2(SIZE)
//  mem_rdata       in   32  word for the request issued in the previous cycle
//  redirect_valid  in   1   downstream PC redirect, single-cycle pulse
//  redirect_pc     in   32  redirect target; bits [1:0] forced to 0
//  out_valid       out  1   out_* hold a fetched instruction
//  out_ready       in   1   consumer accepts when out_valid && out_ready
//  out_instruction out  32  fetched word
//  out_pc          out  32  PC of out_instruction
//  out_pc_plus4    out  32  out_pc + 4, wraps mod 2^32
// BEHAVIOUR
//  Reset: fetch_pc=RESET_PC; FIFO empty; inflight=0; epoch=0; mem_req=0,
//   out_valid=0. out_instruction/out_pc/out_pc_plus4 = 0 while empty.
//  Issue: mem_req = !reset && !redirect_valid && (occ + inflight - pop < FIFO_DEPTH);
//   pop = out_valid && out_ready (combinational path out_ready->mem_req allowed).
//   On issue: fetch_pc += 4; inflight <= 1 and tagged with current epoch and PC.
//  Response: cycle after issue, mem_rdata and tagged PC are pushed if tag epoch ==
//   current epoch, else dropped. A pushed entry is visible on out_* next cycle.
//  Latency: reset deassert in cycle 0 -> req cycle 0 -> out_valid cycle 2.
//   Steady state with out_ready=1: one instruction per cycle, no bubbles.
//  Handshake: out_* stable while out_valid && !out_ready; in-order; no duplicates.
//  Redirect (cycle N): FIFO flushed at end of N; epoch toggles; in-flight
//   response arriving in N+1 dropped; fetch_pc <= {redirect_pc[31:2],2'b00};
//   no req in N; req for target in N+1; out_valid for target in N+3.
//  Redirect with pop in same cycle: pop completes (consumer owns that word),
//   then flush. Redirect during reset: reset wins.
//  Back-to-back redirects: the last one wins; each drops the prior in-flight read.
//  Full: FIFO full, out_ready=0 -> mem_req=0, fetch_pc holds.
//  Address wrap: mem_addr truncated to AW bits; fetch_pc wraps mod 2^32.
//  Reset mid-operation: all state returns to reset values next edge; any
//   response to a pre-reset request is discarded.
// STRUCTURE
//  Shared header: PROGRAM_MEMORY_SIZE_WORDS, RESET_PC, NOP encoding 32'h00000013.
//  Sub-module fetch_fifo: sync FIFO, WIDTH=64 ({pc,instr}), DEPTH, flush input,
//   push/pop same cycle legal when full (pop frees the slot first).
//  Top: fetch_pc register, inflight/epoch/tag registers, issue credit logic.
// TESTING
//  Reset, out_ready=1, memory word i = i: out_pc 0,4,8,... one per cycle from cycle 2.
//  out_ready=0 for 5 cycles: out_valid held, out_pc=0 stable, mem_req low once
//   FIFO full (2); release -> 0,4,8 delivered in order, no gap, no duplicate.
//  Redirect to 0x40 while 0x08 in flight: 0x08 never appears; next out_pc=0x40
//   exactly 3 cycles after redirect; redirect_pc 0x43 behaves as 0x40.
//  Redirect in same cycle as accepted pop of 0x04: 0x04 counted delivered once,
//   next delivered out_pc = target.
//  PC 0xFC with SIZE=64: mem_addr = 63, next mem_addr = 0, out_pc = 0x100.
//  Assert reset for 1 cycle mid-stream: out_valid=0 next cycle, restart at RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared constants and types for the instruction fetch stage.
package instruction_fetch_pkg;

    localparam int unsigned PMEM_WORDS_DEFAULT = 64;
    localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_0000;
    localparam int unsigned FIFO_DEPTH_DEFAULT = 2;
    localparam logic [31:0] NOP_INSTR          = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Program-memory port, redirect input and fetched-instruction stream of the fetch stage.
interface instruction_fetch_if #(
    parameter int unsigned AW = 6
);
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_rdata;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_instruction;
    logic [31:0]   out_pc;
    logic [31:0]   out_pc_plus4;

    modport master (
        output mem_req, mem_addr, out_valid, out_instruction, out_pc, out_pc_plus4,
        input  mem_rdata, redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  mem_req, mem_addr, out_valid, out_instruction, out_pc, out_pc_plus4,
        output mem_rdata, redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/instruction_fetch_fifo.sv
// Synchronous fetch buffer with flush; a pop frees its slot for a same-cycle push when full.
module fetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PW   = $clog2(DEPTH),
    localparam int unsigned CW   = PW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [CW-1:0]    count,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + CW'(do_push) - CW'(do_pop);
        // Flush drops everything, including a push arriving in the same cycle.
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count      = count_q;
    assign head_valid = (count_q != '0);
    assign head_data  = head_valid ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the fetch PC, issues 1-cycle-latency memory reads and buffers results.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int unsigned PROGRAM_MEMORY_SIZE_WORDS = PMEM_WORDS_DEFAULT,
    parameter logic [31:0] RESET_PC                  = RESET_PC_DEFAULT,
    parameter int unsigned FIFO_DEPTH                = FIFO_DEPTH_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    instruction_fetch_if.master bus
);

    localparam int unsigned AW = $clog2(PROGRAM_MEMORY_SIZE_WORDS);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  tag_pc_q, tag_pc_d;
    logic         inflight_q, inflight_d;
    logic         tag_epoch_q, tag_epoch_d;
    logic         epoch_q, epoch_d;

    logic [CW-1:0] occ;
    logic [CW:0]   credit_used;
    logic          head_valid, pop, issue, push;
    fetch_entry_t  head, push_entry;

    always_comb begin
        pop = head_valid && bus.out_ready;
        // Slots already claimed after this cycle's pop; a new read needs one spare.
        credit_used = {1'b0, occ} + (CW+1)'(inflight_q) - (CW+1)'(pop);
        issue       = !reset && !bus.redirect_valid && (credit_used < (CW+1)'(FIFO_DEPTH));
        push        = inflight_q && (tag_epoch_q == epoch_q) && !bus.redirect_valid;
        push_entry  = '{pc: tag_pc_q, instr: bus.mem_rdata};

        fetch_pc_d = fetch_pc_q;
        if (bus.redirect_valid) begin
            fetch_pc_d = word_align(bus.redirect_pc);
        end else if (issue) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
        inflight_d  = issue;
        tag_pc_d    = issue ? fetch_pc_q : tag_pc_q;
        tag_epoch_d = issue ? epoch_q : tag_epoch_q;
        epoch_d     = epoch_q ^ bus.redirect_valid;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q  <= RESET_PC;
            tag_pc_q    <= '0;
            inflight_q  <= 1'b0;
            tag_epoch_q <= 1'b0;
            epoch_q     <= 1'b0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            tag_pc_q    <= tag_pc_d;
            inflight_q  <= inflight_d;
            tag_epoch_q <= tag_epoch_d;
            epoch_q     <= epoch_d;
        end
    end

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .flush      (bus.redirect_valid),
        .push       (push),
        .push_data  (push_entry),
        .pop        (pop),
        .count      (occ),
        .head_valid (head_valid),
        .head_data  (head)
    );

    assign bus.mem_req         = issue;
    assign bus.mem_addr        = fetch_pc_q[AW+1:2];
    assign bus.out_valid       = head_valid;
    assign bus.out_instruction = head.instr;
    assign bus.out_pc          = head.pc;
    assign bus.out_pc_plus4    = head_valid ? head.pc + 32'd4 : '0;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: vector table, hand-written corner sequences, random stream vs. model.
module tb_instruction_fetch;
    import instruction_fetch_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    instruction_fetch_if #(.AW(6)) bus();

    instruction_fetch #(
        .PROGRAM_MEMORY_SIZE_WORDS (64),
        .RESET_PC                  (32'h0),
        .FIFO_DEPTH                (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [5:0] idx);
        return 32'hC0DE_0000 | {26'd0, idx};
    endfunction

    // Synchronous program memory, one-cycle read latency.
    always @(posedge clk) bus.mem_rdata <= word_of(bus.mem_addr);

    typedef struct {
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        req;
        logic [5:0]  addr;
        logic        vld;
        logic [31:0] pc;
    } vec_t;

    function automatic vec_t v(input logic rdy, input logic rv, input logic [31:0] rpc,
                               input logic req, input logic [5:0] addr,
                               input logic vld, input logic [31:0] pc);
        vec_t r;
        r.rdy = rdy; r.rv = rv; r.rpc = rpc; r.req = req; r.addr = addr; r.vld = vld; r.pc = pc;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic vld, input logic [31:0] pc);
        logic [31:0] p;
        p = pc;
        chk({nm, ".valid"}, 32'(bus.out_valid), 32'(vld));
        if (vld) begin
            chk({nm, ".pc"},    bus.out_pc,          p);
            chk({nm, ".instr"}, bus.out_instruction, word_of(p[7:2]));
            chk({nm, ".plus4"}, bus.out_pc_plus4,    p + 32'd4);
        end else begin
            chk({nm, ".pc0"},    bus.out_pc,          32'h0);
            chk({nm, ".instr0"}, bus.out_instruction, 32'h0);
        end
    endtask

    task automatic chk_req(input string nm, input logic req, input logic [5:0] addr);
        chk({nm, ".req"}, 32'(bus.mem_req), 32'(req));
        if (req) chk({nm, ".addr"}, 32'(bus.mem_addr), 32'(addr));
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = pc;
        @(negedge clk);
        chk_req("redir", 1'b0, 6'd0);
        tick();
        bus.redirect_valid = 1'b0;
    endtask

    vec_t        tbl[16];
    logic [31:0] exp_pc, exp_fetch, prev_pc;
    int          outstanding, idle;
    logic        prev_hold;

    initial begin
        bus.out_ready      = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;

        tbl[0]  = v(1'b1, 1'b0, 32'h0,  1'b1, 6'd0,  1'b0, 32'h0);
        tbl[1]  = v(1'b1, 1'b0, 32'h0,  1'b1, 6'd1,  1'b0, 32'h0);
        tbl[2]  = v(1'b1, 1'b0, 32'h0,  1'b1, 6'd2,  1'b1, 32'h0);
        tbl[3]  = v(1'b0, 1'b0, 32'h0,  1'b0, 6'd0,  1'b1, 32'h4);
        tbl[4]  = v(1'b0, 1'b0, 32'h0,  1'b0, 6'd0,  1'b1, 32'h4);
        tbl[5]  = v(1'b0, 1'b0, 32'h0,  1'b0, 6'd0,  1'b1, 32'h4);
        tbl[6]  = v(1'b0, 1'b0, 32'h0,  1'b0, 6'd0,  1'b1, 32'h4);
        tbl[7]  = v(1'b0, 1'b0, 32'h0,  1'b0, 6'd0,  1'b1, 32'h4);
        tbl[8]  = v(1'b1, 1'b0, 32'h0,  1'b1, 6'd3,  1'b1, 32'h4);
        tbl[9]  = v(1'b1, 1'b0, 32'h0,  1'b1, 6'd4,  1'b1, 32'h8);
        tbl[10] = v(1'b1, 1'b1, 32'h43, 1'b0, 6'd0,  1'b1, 32'hC);
        tbl[11] = v(1'b1, 1'b0, 32'h0,  1'b1, 6'd16, 1'b0, 32'h0);
        tbl[12] = v(1'b1, 1'b0, 32'h0,  1'b1, 6'd17, 1'b0, 32'h0);
        tbl[13] = v(1'b1, 1'b0, 32'h0,  1'b1, 6'd18, 1'b1, 32'h40);
        tbl[14] = v(1'b1, 1'b0, 32'h0,  1'b1, 6'd19, 1'b1, 32'h44);
        tbl[15] = v(1'b1, 1'b0, 32'h0,  1'b1, 6'd20, 1'b1, 32'h48);

        // Reset state.
        tick();
        @(negedge clk);
        chk_req("rst", 1'b0, 6'd0);
        chk_out("rst", 1'b0, 32'h0);
        tick();
        reset = 1'b0;

        // Start-up latency, stall with full buffer, redirect to 0x43 alongside a pop of 0xC.
        for (int i = 0; i < 16; i++) begin
            bus.out_ready      = tbl[i].rdy;
            bus.redirect_valid = tbl[i].rv;
            bus.redirect_pc    = tbl[i].rpc;
            @(negedge clk);
            chk_req($sformatf("vec%0d", i), tbl[i].req, tbl[i].addr);
            chk_out($sformatf("vec%0d", i), tbl[i].vld, tbl[i].pc);
            tick();
        end
        bus.redirect_valid = 1'b0;

        // Back-to-back redirects: only the second target is fetched.
        redirect_to(32'h20);
        @(negedge clk);
        chk_out("b2b.n1", 1'b0, 32'h0);
        redirect_to(32'h80);
        @(negedge clk);
        chk_req("b2b.n1", 1'b1, 6'd32);
        chk_out("b2b.n1", 1'b0, 32'h0);
        tick();
        @(negedge clk);
        chk_out("b2b.n2", 1'b0, 32'h0);
        tick();
        @(negedge clk);
        chk_out("b2b.n3", 1'b1, 32'h80);
        tick();

        // Memory index wrap at the top of the 64-word program memory.
        redirect_to(32'hFC);
        @(negedge clk);
        chk_req("wrap.n1", 1'b1, 6'd63);
        tick();
        @(negedge clk);
        chk_req("wrap.n2", 1'b1, 6'd0);
        tick();
        @(negedge clk);
        chk_out("wrap.n3", 1'b1, 32'hFC);
        tick();
        @(negedge clk);
        chk_out("wrap.n4", 1'b1, 32'h100);
        tick();

        // 32-bit PC wrap; low redirect bits ignored.
        redirect_to(32'hFFFF_FFFE);
        @(negedge clk);
        chk_req("pcwrap.n1", 1'b1, 6'd63);
        tick();
        @(negedge clk);
        chk_req("pcwrap.n2", 1'b1, 6'd0);
        tick();
        @(negedge clk);
        chk_out("pcwrap.n3", 1'b1, 32'hFFFF_FFFC);
        chk("pcwrap.plus4", bus.out_pc_plus4, 32'h0);
        tick();
        @(negedge clk);
        chk_out("pcwrap.n4", 1'b1, 32'h0);
        tick();

        // One-cycle reset in the middle of a running stream.
        reset = 1'b1;
        @(negedge clk);
        chk_req("midrst", 1'b0, 6'd0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk_out("midrst.c0", 1'b0, 32'h0);
        chk_req("midrst.c0", 1'b1, 6'd0);
        tick();
        @(negedge clk);
        chk_out("midrst.c1", 1'b0, 32'h0);
        tick();
        @(negedge clk);
        chk_out("midrst.c2", 1'b1, 32'h0);
        tick();

        // Random stream against an in-order delivery model.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_pc      = 32'h0;
        exp_fetch   = 32'h0;
        outstanding = 0;
        idle        = 0;
        prev_hold   = 1'b0;
        prev_pc     = 32'h0;
        for (int c = 0; c < 600; c++) begin
            bus.out_ready      = ($urandom_range(0, 3) != 0);
            bus.redirect_valid = ($urandom_range(0, 15) == 0);
            bus.redirect_pc    = $urandom;
            @(negedge clk);
            if (prev_hold) begin
                chk("rnd.hold.valid", 32'(bus.out_valid), 32'h1);
                chk("rnd.hold.pc", bus.out_pc, prev_pc);
            end
            if (bus.out_valid) begin
                chk("rnd.pc", bus.out_pc, exp_pc);
                chk("rnd.instr", bus.out_instruction, word_of(exp_pc[7:2]));
                chk("rnd.plus4", bus.out_pc_plus4, exp_pc + 32'd4);
                idle = 0;
            end else begin
                idle++;
            end
            chk("rnd.live", 32'(idle < 3), 32'h1);
            if (bus.redirect_valid) chk("rnd.redir_req", 32'(bus.mem_req), 32'h0);
            if (bus.mem_req) chk("rnd.addr", 32'(bus.mem_addr), 32'(exp_fetch[7:2]));
            if (bus.out_valid && bus.out_ready) begin
                exp_pc = exp_pc + 32'd4;
                outstanding--;
            end
            if (bus.mem_req) begin
                exp_fetch = exp_fetch + 32'd4;
                outstanding++;
            end
            chk("rnd.credit", 32'(outstanding <= 2), 32'h1);
            prev_hold = bus.out_valid && !bus.out_ready && !bus.redirect_valid;
            prev_pc   = bus.out_pc;
            if (bus.redirect_valid) begin
                exp_pc      = {bus.redirect_pc[31:2], 2'b00};
                exp_fetch   = exp_pc;
                outstanding = 0;
                idle        = 0;
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
